// File: rtl/voice_allocator.sv
// voice_allocator -- polyphony controller for a bank of oscillator voices.
//
// Turns key press/release pulses into per-voice enable and divider settings.
// A new note goes to the lowest-index free voice. When every voice is busy,
// the least recently allocated voice is stolen. All outputs are registered.
//
// Ports:
//   clk            system clock (10 MHz)
//   nrst           asynchronous active-low reset
//   key_press      single-cycle pulse: key_idx pressed
//   key_release    single-cycle pulse: key_idx released
//   key_idx        note 0..12 (C4..C5); 13..15 are ignored
//   oct_shift      octave up-shift 0..3, sampled with key_press
//   all_off        panic: clears every enable, suppresses that cycle's events
//   voice_en       per-voice oscillator enable
//   voice_divider  per-voice divider, voice i at [16i+15:16i]
//   voice_key      key held by each voice, voice i at [4i+3:4i]
//   full           every voice enabled
//   steal          one-cycle pulse: the last press stole a voice
module voice_allocator #(
   parameter int NUM_VOICES = 4
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       key_press,
   input  logic                       key_release,
   input  logic [3:0]                 key_idx,
   input  logic [1:0]                 oct_shift,
   input  logic                       all_off,
   output logic [NUM_VOICES-1:0]      voice_en,
   output logic [16*NUM_VOICES-1:0]   voice_divider,
   output logic [4*NUM_VOICES-1:0]    voice_key,
   output logic                       full,
   output logic                       steal
);

   localparam int RW = $clog2(NUM_VOICES);
   localparam logic [RW-1:0] OLDEST = RW'(NUM_VOICES - 1);

   // Clock divider for each chromatic note at 10 MHz.
   function automatic logic [15:0] note_divider(input logic [3:0] k);
      case (k)
         4'd0:    return 16'd38222;
         4'd1:    return 16'd36078;
         4'd2:    return 16'd34053;
         4'd3:    return 16'd32141;
         4'd4:    return 16'd30337;
         4'd5:    return 16'd28634;
         4'd6:    return 16'd27028;
         4'd7:    return 16'd25510;
         4'd8:    return 16'd24079;
         4'd9:    return 16'd22727;
         4'd10:   return 16'd21452;
         4'd11:   return 16'd20248;
         4'd12:   return 16'd19111;
         default: return 16'd1;
      endcase
   endfunction

   logic [NUM_VOICES-1:0] en_reg, en_next;
   logic [15:0]           div_reg  [NUM_VOICES];
   logic [15:0]           div_next [NUM_VOICES];
   logic [3:0]            key_reg  [NUM_VOICES];
   logic [3:0]            key_next [NUM_VOICES];
   logic [RW-1:0]         rank_reg [NUM_VOICES];   // 0 = newest allocation
   logic [RW-1:0]         rank_next[NUM_VOICES];
   logic                  full_reg, full_next;
   logic                  steal_reg, steal_next;

   logic                  key_ok, do_release, do_press;
   logic [NUM_VOICES-1:0] rel_match, en_after_rel, press_match;
   logic                  hit, any_free;
   logic [RW-1:0]         free_idx, oldest_idx, target_idx;
   logic [15:0]           new_div;

   assign key_ok     = (key_idx <= 4'd12);
   assign do_release = key_release && key_ok && !all_off;
   assign do_press   = key_press && key_ok && !all_off;
   assign new_div    = note_divider(key_idx) >> oct_shift;

   // The press sees the voice map after the release, so a same-cycle
   // release+press of one key frees the voice and then reallocates it.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_match
         assign rel_match[gi]    = en_reg[gi] && (key_reg[gi] == key_idx);
         assign en_after_rel[gi] = en_reg[gi] && !(do_release && rel_match[gi]);
         assign press_match[gi]  = en_after_rel[gi] && (key_reg[gi] == key_idx);
      end
   endgenerate

   assign hit      = |press_match;
   assign any_free = ~&en_after_rel;

   // Lowest-index free voice and the voice holding the oldest rank.
   always_comb begin
      free_idx   = '0;
      oldest_idx = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (!en_after_rel[i]) free_idx = RW'(i);
      end
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (rank_reg[i] == OLDEST) oldest_idx = RW'(i);
      end
   end

   always_comb begin
      en_next    = en_after_rel;
      div_next   = div_reg;
      key_next   = key_reg;
      rank_next  = rank_reg;
      steal_next = 1'b0;
      target_idx = any_free ? free_idx : oldest_idx;
      if (all_off) begin
         en_next = '0;
      end else if (do_press) begin
         if (hit) begin
            // Retrigger: only the pitch (octave) is refreshed.
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (press_match[i]) div_next[i] = new_div;
            end
         end else begin
            steal_next = !any_free;
            for (int i = 0; i < NUM_VOICES; i++) begin
               if (RW'(i) == target_idx) begin
                  en_next[i]   = 1'b1;
                  div_next[i]  = new_div;
                  key_next[i]  = key_idx;
                  rank_next[i] = '0;
               end else if (rank_reg[i] < rank_reg[target_idx]) begin
                  rank_next[i] = rank_reg[i] + RW'(1);
               end
            end
         end
      end
      full_next = &en_next;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         en_reg    <= '0;
         full_reg  <= 1'b0;
         steal_reg <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            div_reg[i]  <= 16'd1;
            key_reg[i]  <= 4'd0;
            rank_reg[i] <= RW'(i);
         end
      end else begin
         en_reg    <= en_next;
         div_reg   <= div_next;
         key_reg   <= key_next;
         rank_reg  <= rank_next;
         full_reg  <= full_next;
         steal_reg <= steal_next;
      end
   end

   assign voice_en = en_reg;
   assign full     = full_reg;
   assign steal    = steal_reg;

   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_pack
         assign voice_divider[16*gi +: 16] = div_reg[gi];
         assign voice_key[4*gi +: 4]       = key_reg[gi];
      end
   endgenerate

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator -- self-checking bench for voice_allocator.
//
// Keeps a behavioural model of the voice pool (enable/divider/key per voice
// plus an age list, newest first) and compares every DUT output against it
// on each falling clock edge. Directed scenarios add literal expectations,
// followed by a randomized event phase.
module tb_voice_allocator;

   localparam int NV = 4;

   logic            tb_clk = 1'b0;
   logic            nrst;
   logic            key_press, key_release, all_off;
   logic [3:0]      key_idx;
   logic [1:0]      oct_shift;
   logic [NV-1:0]   voice_en;
   logic [16*NV-1:0] voice_divider;
   logic [4*NV-1:0] voice_key;
   logic            full, steal;

   int n_checks = 0;
   int n_errors = 0;

   voice_allocator #(.NUM_VOICES(NV)) dut (
      .clk          (tb_clk),
      .nrst         (nrst),
      .key_press    (key_press),
      .key_release  (key_release),
      .key_idx      (key_idx),
      .oct_shift    (oct_shift),
      .all_off      (all_off),
      .voice_en     (voice_en),
      .voice_divider(voice_divider),
      .voice_key    (voice_key),
      .full         (full),
      .steal        (steal)
   );

   always #5 tb_clk = ~tb_clk;

   // ---------------- behavioural model ----------------
   int unsigned note_tab [13] = '{38222, 36078, 34053, 32141, 30337, 28634,
                                  27028, 25510, 24079, 22727, 21452, 20248, 19111};
   logic        m_en  [NV];
   logic [15:0] m_div [NV];
   logic [3:0]  m_key [NV];
   logic        m_steal;
   int          age_q [$];   // front = most recently allocated voice

   task automatic model_reset();
      for (int v = 0; v < NV; v++) begin
         m_en[v]  = 1'b0;
         m_div[v] = 16'd1;
         m_key[v] = 4'd0;
      end
      m_steal = 1'b0;
      age_q.delete();
      for (int v = 0; v < NV; v++) age_q.push_back(v);
   endtask

   task automatic model_step();
      int found, tgt;
      logic [15:0] d;
      m_steal = 1'b0;
      if (all_off) begin
         for (int v = 0; v < NV; v++) m_en[v] = 1'b0;
      end else if (key_idx <= 4'd12) begin
         if (key_release) begin
            for (int v = 0; v < NV; v++)
               if (m_en[v] && m_key[v] == key_idx) m_en[v] = 1'b0;
         end
         if (key_press) begin
            d = 16'(note_tab[int'(key_idx)] >> oct_shift);
            found = -1;
            for (int v = 0; v < NV; v++)
               if (m_en[v] && m_key[v] == key_idx) found = v;
            if (found >= 0) begin
               m_div[found] = d;
            end else begin
               tgt = -1;
               for (int v = 0; v < NV; v++)
                  if (!m_en[v] && tgt < 0) tgt = v;
               if (tgt < 0) begin
                  tgt = age_q[$];
                  m_steal = 1'b1;
               end
               for (int i = 0; i < age_q.size(); i++) begin
                  if (age_q[i] == tgt) begin
                     age_q.delete(i);
                     break;
                  end
               end
               age_q.push_front(tgt);
               m_en[tgt]  = 1'b1;
               m_div[tgt] = d;
               m_key[tgt] = key_idx;
            end
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process: outputs vs model on every falling edge.
   initial begin
      logic [NV-1:0]    e_en;
      logic [16*NV-1:0] e_div;
      logic [4*NV-1:0]  e_key;
      forever begin
         @(negedge tb_clk);
         for (int v = 0; v < NV; v++) begin
            e_en[v]          = m_en[v];
            e_div[16*v +: 16] = m_div[v];
            e_key[4*v +: 4]   = m_key[v];
         end
         chk("model_en",    64'(voice_en),      64'(e_en));
         chk("model_div",   64'(voice_divider), 64'(e_div));
         chk("model_key",   64'(voice_key),     64'(e_key));
         chk("model_full",  64'(full),          64'(&e_en));
         chk("model_steal", 64'(steal),         64'(m_steal));
      end
   end

   // One transaction: inputs applied after a falling edge, sampled on the
   // next rising edge, results visible at the following falling edge.
   task automatic drive(input logic p, input logic r, input logic [3:0] k,
                        input logic [1:0] o, input logic off);
      key_press   = p;
      key_release = r;
      key_idx     = k;
      oct_shift   = o;
      all_off     = off;
      @(posedge tb_clk);
      if (nrst) model_step();
      @(negedge tb_clk);
      $display("t=%0t press=%0b rel=%0b key=%0d oct=%0d off=%0b -> en=%b full=%0b steal=%0b key=%h",
               $time, p, r, k, o, off, voice_en, full, steal, voice_key);
      key_press   = 1'b0;
      key_release = 1'b0;
      all_off     = 1'b0;
   endtask

   initial begin
      logic [3:0] k;
      logic       p, r, off;
      nrst        = 1'b0;
      key_press   = 1'b0;
      key_release = 1'b0;
      key_idx     = 4'd0;
      oct_shift   = 2'd0;
      all_off     = 1'b0;
      model_reset();

      // Power-on: a press during reset changes nothing.
      @(negedge tb_clk);
      drive(1'b1, 1'b0, 4'd3, 2'd0, 1'b0);
      chk("rst_en",    64'(voice_en), 64'h0);
      chk("rst_div",   64'(voice_divider), 64'h0001_0001_0001_0001);
      chk("rst_full",  64'(full), 64'h0);
      chk("rst_steal", 64'(steal), 64'h0);
      nrst = 1'b1;
      @(negedge tb_clk);

      // Single note.
      drive(1'b1, 1'b0, 4'd9, 2'd0, 1'b0);
      chk("n9_en",  64'(voice_en), 64'b0001);
      chk("n9_div", 64'(voice_divider[15:0]), 64'd22727);
      drive(1'b0, 1'b1, 4'd9, 2'd0, 1'b0);
      chk("n9_rel_en",  64'(voice_en), 64'b0000);
      chk("n9_rel_div", 64'(voice_divider[15:0]), 64'd22727);

      // Octave shift and retrigger.
      drive(1'b1, 1'b0, 4'd0, 2'd2, 1'b0);
      chk("oct2_div", 64'(voice_divider[15:0]), 64'd9555);
      drive(1'b1, 1'b0, 4'd0, 2'd1, 1'b0);
      chk("retrig_div", 64'(voice_divider[15:0]), 64'd19111);
      chk("retrig_en",  64'(voice_en), 64'b0001);

      // Fill and steal.
      drive(1'b1, 1'b0, 4'd0, 2'd0, 1'b0);
      drive(1'b1, 1'b0, 4'd2, 2'd0, 1'b0);
      drive(1'b1, 1'b0, 4'd4, 2'd0, 1'b0);
      drive(1'b1, 1'b0, 4'd5, 2'd0, 1'b0);
      chk("fill_en",   64'(voice_en), 64'b1111);
      chk("fill_full", 64'(full), 64'h1);
      drive(1'b1, 1'b0, 4'd7, 2'd0, 1'b0);
      chk("steal_key",   64'(voice_key[3:0]), 64'd7);
      chk("steal_div",   64'(voice_divider[15:0]), 64'd25510);
      chk("steal_pulse", 64'(steal), 64'h1);
      drive(1'b0, 1'b0, 4'd0, 2'd0, 1'b0);
      chk("steal_end", 64'(steal), 64'h0);

      // Free slot reuse and LRU order.
      drive(1'b0, 1'b1, 4'd2, 2'd0, 1'b0);
      chk("rel2_en", 64'(voice_en), 64'b1101);
      drive(1'b1, 1'b0, 4'd11, 2'd0, 1'b0);
      chk("reuse_key",   64'(voice_key[7:4]), 64'd11);
      chk("reuse_div",   64'(voice_divider[31:16]), 64'd20248);
      chk("reuse_steal", 64'(steal), 64'h0);
      drive(1'b1, 1'b0, 4'd12, 2'd0, 1'b0);
      chk("steal2_key",   64'(voice_key[11:8]), 64'd12);
      chk("steal2_pulse", 64'(steal), 64'h1);

      // Corner events.
      drive(1'b1, 1'b0, 4'd14, 2'd0, 1'b0);
      chk("inval_en",    64'(voice_en), 64'b1111);
      chk("inval_steal", 64'(steal), 64'h0);
      drive(1'b1, 1'b1, 4'd5, 2'd3, 1'b0);
      chk("relpress_en",  64'(voice_en), 64'b1111);
      chk("relpress_div", 64'(voice_divider[63:48]), 64'd3579);
      chk("relpress_steal", 64'(steal), 64'h0);
      drive(1'b1, 1'b0, 4'd3, 2'd0, 1'b1);
      chk("alloff_en",   64'(voice_en), 64'h0);
      chk("alloff_full", 64'(full), 64'h0);
      drive(1'b1, 1'b0, 4'd1, 2'd0, 1'b0);
      drive(1'b1, 1'b0, 4'd6, 2'd1, 1'b0);

      // Asynchronous reset between clock edges.
      @(posedge tb_clk);
      #2;
      nrst = 1'b0;
      model_reset();
      #1;
      chk("arst_en",   64'(voice_en), 64'h0);
      chk("arst_div",  64'(voice_divider), 64'h0001_0001_0001_0001);
      chk("arst_full", 64'(full), 64'h0);
      @(negedge tb_clk);
      drive(1'b1, 1'b0, 4'd2, 2'd0, 1'b0);
      nrst = 1'b1;
      @(negedge tb_clk);

      // Randomized events.
      for (int n = 0; n < 400; n++) begin
         p   = ($urandom_range(0, 99) < 55);
         r   = ($urandom_range(0, 99) < 35);
         off = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) == 0) k = 4'(13 + $urandom_range(0, 2));
         else                          k = 4'($urandom_range(0, 12));
         if (r && !p && $urandom_range(0, 1) == 1) k = m_key[$urandom_range(0, NV - 1)];
         drive(p, r, k, 2'($urandom_range(0, 3)), off);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
